// File: rtl/ft601_device_model.sv
// Chip-side model of the FT601 245 synchronous FIFO bus: an RX FIFO the FPGA reads and a TX FIFO
// the FPGA writes, with host-facing ready/valid streams and sticky protocol-error flags.
module ft601_device_model #(
   parameter int unsigned RxDepth = 16,
   parameter int unsigned TxDepth = 16
) (
   input  logic        usb_clk_i,
   input  logic        usb_rst_ni,
   input  logic [31:0] usb_data_i,
   output logic [31:0] usb_data_o,
   output logic        usb_data_oe,
   input  logic [3:0]  usb_be_i,
   output logic [3:0]  usb_be_o,
   output logic        usb_rxf_no,
   output logic        usb_txe_no,
   input  logic        usb_rd_ni,
   input  logic        usb_oe_ni,
   input  logic        usb_wr_ni,
   input  logic        usb_fpga_rst_ni,
   input  logic        host_rx_valid_i,
   output logic        host_rx_ready_o,
   input  logic [31:0] host_rx_data_i,
   input  logic [3:0]  host_rx_be_i,
   output logic        host_tx_valid_o,
   input  logic        host_tx_ready_i,
   output logic [31:0] host_tx_data_o,
   output logic [3:0]  host_tx_be_o,
   input  logic        tx_stall_i,
   output logic        err_rd_empty_o,
   output logic        err_wr_full_o,
   output logic        bus_contention_o
);
   localparam int unsigned RxAw = $clog2(RxDepth);
   localparam int unsigned TxAw = $clog2(TxDepth);
   localparam logic [RxAw:0] RxOne = 1;
   localparam logic [TxAw:0] TxOne = 1;

   logic [35:0]   rx_mem_q [RxDepth];
   logic [35:0]   tx_mem_q [TxDepth];
   logic [RxAw:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [TxAw:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic          rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
   logic          oe_q, oe_d, run_q, run_d;
   logic          err_rd_q, err_rd_d, err_wr_q, err_wr_d, cont_q, cont_d;
   logic          rx_empty, rx_full, tx_empty, tx_full_d;
   logic          rx_push, rx_pop, tx_push, tx_pop;
   logic [35:0]   rx_head, tx_head;

   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = (rx_wr_q[RxAw] != rx_rd_q[RxAw]) &&
                     (rx_wr_q[RxAw-1:0] == rx_rd_q[RxAw-1:0]);
   assign tx_empty = (tx_wr_q == tx_rd_q);

   assign rx_push = host_rx_valid_i && host_rx_ready_o;
   assign rx_pop  = !usb_oe_ni && !usb_rd_ni && !rxf_n_q;
   assign tx_push = !usb_wr_ni && !txe_n_q;
   assign tx_pop  = host_tx_valid_o && host_tx_ready_i;

   assign rx_head = rx_mem_q[rx_rd_q[RxAw-1:0]];
   assign tx_head = tx_mem_q[tx_rd_q[TxAw-1:0]];

   always_comb begin
      rx_wr_d = rx_wr_q;
      rx_rd_d = rx_rd_q;
      tx_wr_d = tx_wr_q;
      tx_rd_d = tx_rd_q;
      oe_d    = !usb_oe_ni;
      run_d   = usb_fpga_rst_ni;
      if (rx_push) rx_wr_d = rx_wr_q + RxOne;
      if (rx_pop)  rx_rd_d = rx_rd_q + RxOne;
      if (tx_push) tx_wr_d = tx_wr_q + TxOne;
      if (tx_pop)  tx_rd_d = tx_rd_q + TxOne;
      // FPGA-driven chip reset flushes both FIFOs but leaves the error flags alone.
      if (!usb_fpga_rst_ni) begin
         rx_wr_d = '0;
         rx_rd_d = '0;
         tx_wr_d = '0;
         tx_rd_d = '0;
         oe_d    = 1'b0;
      end
      tx_full_d = (tx_wr_d[TxAw] != tx_rd_d[TxAw]) &&
                  (tx_wr_d[TxAw-1:0] == tx_rd_d[TxAw-1:0]);
      rxf_n_d   = (rx_wr_d == rx_rd_d) || !usb_fpga_rst_ni;
      txe_n_d   = tx_full_d || tx_stall_i || !usb_fpga_rst_ni;
      err_rd_d  = err_rd_q || (!usb_rd_ni && rxf_n_q);
      err_wr_d  = err_wr_q || (!usb_wr_ni && txe_n_q);
      cont_d    = cont_q || (oe_q && !usb_wr_ni);
   end

   always_ff @(posedge usb_clk_i or negedge usb_rst_ni) begin
      if (!usb_rst_ni) begin
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rxf_n_q  <= 1'b1;
         txe_n_q  <= 1'b1;
         oe_q     <= 1'b0;
         run_q    <= 1'b0;
         err_rd_q <= 1'b0;
         err_wr_q <= 1'b0;
         cont_q   <= 1'b0;
      end else begin
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         rxf_n_q  <= rxf_n_d;
         txe_n_q  <= txe_n_d;
         oe_q     <= oe_d;
         run_q    <= run_d;
         err_rd_q <= err_rd_d;
         err_wr_q <= err_wr_d;
         cont_q   <= cont_d;
      end
   end

   always_ff @(posedge usb_clk_i) begin
      if (rx_push) rx_mem_q[rx_wr_q[RxAw-1:0]] <= {host_rx_be_i, host_rx_data_i};
      if (tx_push) tx_mem_q[tx_wr_q[TxAw-1:0]] <= {usb_be_i, usb_data_i};
   end

   assign usb_data_oe      = oe_q;
   assign usb_data_o       = (oe_q && !rx_empty) ? rx_head[31:0] : '0;
   assign usb_be_o         = (oe_q && !rx_empty) ? rx_head[35:32] : '0;
   assign usb_rxf_no       = rxf_n_q;
   assign usb_txe_no       = txe_n_q;
   // Held low until the first edge out of reset so no push can land mid-reset.
   assign host_rx_ready_o  = run_q && !rx_full;
   assign host_tx_valid_o  = !tx_empty;
   assign host_tx_data_o   = tx_head[31:0];
   assign host_tx_be_o     = tx_head[35:32];
   assign err_rd_empty_o   = err_rd_q;
   assign err_wr_full_o    = err_wr_q;
   assign bus_contention_o = cont_q;
endmodule
